rand_access_checker: RTL

//  Consumes the 32-bit stream from the XorShift128 generator over a valid/ready handshake.
//  For each accepted word it writes rnd[DATA_BITS-1:0] to an internal 2^ADDR_BITS-entry RAM
//  at address rnd[ADDR_BITS-1:0], reads that address back and compares the result.
//  It runs a fixed-length random-access self-test and reports pass/fail plus a capture of
//  the first error. This is the checker stage downstream of the random generator.

---
 rtl/rand_access_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rand_access_checker.sv
// Random-access RAM self-test checker.
// Accepts generator words over valid/ready, writes each word's data field to an
// internal RAM at the word's address field, reads it back and compares. A run is
// TEST_SIZE transactions; the result is pass/fail plus a capture of the first error.
module rand_access_checker #(
    parameter int ADDR_BITS    = 5,
    parameter int DATA_BITS    = 16,
    parameter int TEST_SIZE    = 16,
    parameter int ERR_CNT_BITS = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    inject_err,
    input  logic                    rnd_valid,
    input  logic [31:0]             rnd,
    output logic                    rnd_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [31:0]             txn_count,
    output logic [ERR_CNT_BITS-1:0] err_count,
    output logic [ADDR_BITS-1:0]    first_err_addr,
    output logic [DATA_BITS-1:0]    first_err_exp,
    output logic [DATA_BITS-1:0]    first_err_got
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_READ   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int                    DEPTH       = 1 << ADDR_BITS;
    localparam logic [31:0]           TEST_SIZE_W = 32'(TEST_SIZE);
    localparam logic [ERR_CNT_BITS-1:0] ERR_MAX   = '1;

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [DATA_BITS-1:0]    data_q;
    logic [DATA_BITS-1:0]    rdata_q;
    logic [31:0]             txn_q, txn_d;
    logic [ERR_CNT_BITS-1:0] err_q, err_d;
    logic [ADDR_BITS-1:0]    fe_addr_q, fe_addr_d;
    logic [DATA_BITS-1:0]    fe_exp_q, fe_exp_d;
    logic [DATA_BITS-1:0]    fe_got_q, fe_got_d;

    logic [DATA_BITS-1:0]    mem [DEPTH];
    logic [DATA_BITS-1:0]    inj_mask;
    logic [DATA_BITS-1:0]    got;
    logic [31:0]             txn_inc;
    logic                    accept;
    logic                    start_ok;
    logic                    mismatch;
    // Upper generator bits beyond the address/data fields are intentionally ignored.
    logic                    unused_rnd_parity;

    assign unused_rnd_parity = ^rnd;

    assign accept   = (state_q == S_ACCEPT) && rnd_valid;
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign txn_inc  = txn_q + 32'd1;
    assign got      = rdata_q ^ inj_mask;
    assign mismatch = (got != data_q);

    // Injection mask: only bit 0 of the read data can be flipped.
    always_comb begin
        inj_mask    = '0;
        inj_mask[0] = inject_err;
    end

    // State register; reset aborts any run immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_ACCEPT;
            S_ACCEPT: if (rnd_valid) state_d = S_READ;
            S_READ:   state_d = S_CHECK;
            S_CHECK:  state_d = (txn_inc == TEST_SIZE_W) ? S_DONE : S_ACCEPT;
            S_DONE:   if (start_ok) state_d = S_ACCEPT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state and result registers.
    always_comb begin
        rnd_ready      = (state_q == S_ACCEPT);
        busy           = (state_q == S_ACCEPT) || (state_q == S_READ) || (state_q == S_CHECK);
        done           = (state_q == S_DONE);
        pass           = (state_q == S_DONE) && (err_q == '0);
        txn_count      = txn_q;
        err_count      = err_q;
        first_err_addr = fe_addr_q;
        first_err_exp  = fe_exp_q;
        first_err_got  = fe_got_q;
    end

    // Result counters and first-error capture: cleared on start, updated in CHECK.
    always_comb begin
        txn_d     = txn_q;
        err_d     = err_q;
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;
        if (start_ok) begin
            txn_d     = '0;
            err_d     = '0;
            fe_addr_d = '0;
            fe_exp_d  = '0;
            fe_got_d  = '0;
        end else if (state_q == S_CHECK) begin
            txn_d = txn_inc;
            if (mismatch) begin
                if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                // err_q only ever leaves zero on a mismatch, so zero means "no error yet".
                if (err_q == '0) begin
                    fe_addr_d = addr_q;
                    fe_exp_d  = data_q;
                    fe_got_d  = got;
                end
            end
        end
    end

    // Result registers; cleared by reset because they drive outputs directly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txn_q     <= '0;
            err_q     <= '0;
            fe_addr_q <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
        end else begin
            txn_q     <= txn_d;
            err_q     <= err_d;
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    // RAM write on accept plus the registered read in READ; the write lands one
    // cycle before the read, so the read always sees the freshly written word.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem[rnd[ADDR_BITS-1:0]] <= rnd[DATA_BITS-1:0];
            addr_q                  <= rnd[ADDR_BITS-1:0];
            data_q                  <= rnd[DATA_BITS-1:0];
        end
        if (state_q == S_READ) begin
            rdata_q <= mem[addr_q];
        end
    end

endmodule
